// File: rtl/fixed_div_if.sv
// fixed_div_if -- handshake and data bundle for the fixed-point divider.
//   start_i : request a division (requester -> divider)
//   a_i     : dividend, signed Q(WIDTH-FRAC).FRAC
//   b_i     : divisor, same format
//   busy_o  : division in progress
//   done_o  : one-cycle pulse, result and flags valid
//   div_o   : quotient, held until the next done_o
//   div0_o  : result came from a zero divisor
//   ovf_o   : result was saturated
// Modports: master = requester side, slave = divider side.
interface fixed_div_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] div_o;
  logic             div0_o;
  logic             ovf_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, div_o, div0_o, ovf_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, div_o, div0_o, ovf_o
  );
endinterface

// File: rtl/fixed_div.sv
// fixed_div -- signed fixed-point divider, Q(WIDTH-FRAC).FRAC format.
// Sequential restoring division of (|a| << FRAC) by |b|, one quotient bit per
// cycle, truncating toward zero, with saturation and divide-by-zero handling.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : fixed_div_if.slave (start_i, a_i, b_i / busy_o, done_o, div_o,
//           div0_o, ovf_o)
// Latency: done_o pulses WIDTH+FRAC+1 edges after the accepting edge, or one
// edge after it for a zero divisor.
module fixed_div #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 21
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fixed_div_if.slave  bus
);

  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(QW);
  localparam logic [CW-1:0]    CNT_LAST = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0]    POS_LIM  = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [QW-1:0]    NEG_LIM  = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Magnitude as an unsigned WIDTH-bit value; the most negative input maps
  // to 2^(WIDTH-1) without wrapping.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Apply the sign to a quotient magnitude and clamp; returns {ovf, result}.
  // A negative result may reach 2^(WIDTH-1) in magnitude, a positive one
  // only 2^(WIDTH-1)-1.
  function automatic logic [WIDTH:0] saturate(input logic neg,
                                              input logic [QW-1:0] mag);
    if (!neg && (mag > POS_LIM)) begin
      return {1'b1, MAX_POS};
    end else if (neg && (mag > NEG_LIM)) begin
      return {1'b1, MIN_NEG};
    end else if (neg) begin
      return {1'b0, ~mag[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}};
    end else begin
      return {1'b0, mag[WIDTH-1:0]};
    end
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic              sign_r;
  logic              div0_pend_r;
  logic [QW-1:0]     num_r;       // shifted dividend, consumed MSB first
  logic [WIDTH-1:0]  b_mag_r;
  logic [WIDTH:0]    rem_r;       // partial remainder
  logic [QW-1:0]     quo_r;
  logic [CW-1:0]     count_r;
  logic              busy_r;
  logic              done_r;
  logic [WIDTH-1:0]  div_r;
  logic              div0_r;
  logic              ovf_r;

  logic              b_zero_s;
  logic [WIDTH+1:0]  rem_shift_s;
  logic [WIDTH:0]    rem_diff_s;
  logic              q_bit_s;
  logic [WIDTH:0]    fin_s;

  assign b_zero_s    = (bus.b_i == {WIDTH{1'b0}});
  assign rem_shift_s = {rem_r, num_r[QW-1]};
  assign q_bit_s     = (rem_shift_s >= {2'b00, b_mag_r});
  // The remainder stays below |b| <= 2^(WIDTH-1), so the shifted value never
  // needs its top bit once the trial subtraction succeeds.
  assign rem_diff_s  = rem_shift_s[WIDTH:0] - {1'b0, b_mag_r};

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start_i is only looked at in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start_i) begin
          if (b_zero_s) begin
            next_state_s = FIN;
          end else begin
            next_state_s = CALC;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == CNT_LAST) begin
          next_state_s = FIN;
        end else begin
          next_state_s = CALC;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand capture and one restoring-division step per CALC cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sign_r      <= 1'b0;
      div0_pend_r <= 1'b0;
      num_r       <= {QW{1'b0}};
      b_mag_r     <= {WIDTH{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      quo_r       <= {QW{1'b0}};
      count_r     <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            // With b=0 the xor reduces to the dividend sign, which selects
            // the divide-by-zero clamp direction.
            sign_r      <= bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1];
            div0_pend_r <= b_zero_s;
            num_r       <= {abs_val(bus.a_i), {FRAC{1'b0}}};
            b_mag_r     <= abs_val(bus.b_i);
            rem_r       <= {(WIDTH+1){1'b0}};
            quo_r       <= {QW{1'b0}};
            count_r     <= b_zero_s ? {CW{1'b0}} : CNT_LOAD;
          end
        end
        CALC: begin
          rem_r   <= q_bit_s ? rem_diff_s : rem_shift_s[WIDTH:0];
          quo_r   <= {quo_r[QW-2:0], q_bit_s};
          num_r   <= {num_r[QW-2:0], 1'b0};
          count_r <= count_r - CNT_LAST;
        end
        FIN: begin
          count_r <= {CW{1'b0}};
        end
        default: begin
          count_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Final result selection: divide-by-zero clamp or signed, saturated quotient.
  always_comb begin
    fin_s = {(WIDTH+1){1'b0}};
    if (div0_pend_r) begin
      fin_s = {1'b0, (sign_r ? MIN_NEG : MAX_POS)};
    end else begin
      fin_s = saturate(sign_r, quo_r);
    end
  end

  // Registered outputs; result and flags update only in FIN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      div_r  <= {WIDTH{1'b0}};
      div0_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (state_r == FIN);
      if (state_r == FIN) begin
        div_r  <= fin_s[WIDTH-1:0];
        div0_r <= div0_pend_r;
        ovf_r  <= fin_s[WIDTH];
      end else begin
        div_r  <= div_r;
        div0_r <= div0_r;
        ovf_r  <= ovf_r;
      end
    end
  end

  assign bus.busy_o = busy_r;
  assign bus.done_o = done_r;
  assign bus.div_o  = div_r;
  assign bus.div0_o = div0_r;
  assign bus.ovf_o  = ovf_r;

endmodule
